// File: rtl/mouth_raster_engine_pkg.sv
// mouth_raster_engine_pkg: shared FSM state type, mouth segment column boundaries
// and width helpers used by the raster engine and its shape evaluator.
package mouth_raster_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAWING,
        S_DRAIN
    } state_t;

    // Mirror-column boundaries of the four mouth segments; columns outside
    // [SEG_A, SEG_E) are never lit.
    localparam int SEG_A = 10;
    localparam int SEG_B = 20;
    localparam int SEG_C = 32;
    localparam int SEG_D = 44;
    localparam int SEG_E = 64;

    function automatic int pixel_size(input int log_power_mod);
        return 3 * log_power_mod;
    endfunction

    function automatic int addr_width(input int rows, input int pixels);
        return (rows * pixels > 1) ? $clog2(rows * pixels) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mouth_raster_engine_shape.sv
// mouth_shape_eval: evaluates the mouth UPPER/LOWER predicates for one raster
// position and carries the result through a clock-enabled pipeline of
// PIPE_DEPTH stages.
// Ports:
//   clk_in, rst_in       clock, asynchronous active-low reset
//   i_en                 pipeline advance (all stages hold when low)
//   i_flush              clears every stage valid on the next edge
//   i_valid              a raster position is being issued this cycle
//   i_row, i_col, i_addr raster position and its linear address
//   i_z, i_color         frame openness and lit colour
//   o_valid/o_addr/o_data  aligned pipeline outputs
module mouth_shape_eval
    import mouth_raster_engine_pkg::*;
#(
    parameter int NUM_PIXELS = 128,
    parameter int PIPE_DEPTH = 4,
    parameter int MIRROR_EN  = 1,
    parameter int RW         = 4,
    parameter int CW         = 7,
    parameter int ZW         = 16,
    parameter int PS         = 12,
    parameter int AW         = 11
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [RW-1:0] i_row,
    input  logic [CW-1:0] i_col,
    input  logic [ZW-1:0] i_z,
    input  logic [PS-1:0] i_color,
    input  logic [AW-1:0] i_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [PS-1:0] o_data
);

    logic [31:0] w_r, w_c, w_z, w_mir, w_m;
    logic        w_off, w_up, w_lo;
    logic [PS-1:0] w_data;

    logic [PIPE_DEPTH-1:0] r_v;
    logic [AW-1:0]         r_a [PIPE_DEPTH];
    logic [PS-1:0]         r_d [PIPE_DEPTH];

    // All predicate arithmetic runs in 32-bit unsigned so no term truncates
    // for any openness below FACE_RES.
    assign w_r   = 32'(i_row);
    assign w_c   = 32'(i_col);
    assign w_z   = 32'(i_z);
    assign w_mir = 32'(NUM_PIXELS - 1) - w_c;
    assign w_m   = (MIRROR_EN != 0 && w_mir < w_c) ? w_mir : w_c;
    // Without mirroring only the right half of the face is drawn.
    assign w_off = (MIRROR_EN == 0) && (w_c >= 32'(NUM_PIXELS / 2));

    assign w_up = (w_m < SEG_A) ? 1'b0 :
                  (w_m < SEG_B) ? (w_m + 6 <= 2 * w_r + 12) :
                  (w_m < SEG_C) ? (4 * w_r + 4 + w_m >= 52) :
                  (w_m < SEG_D) ? (w_m + 15 <= 3 * w_r + 35) :
                  (w_m < SEG_E) ? (4 * w_r + 4 + w_m >= 80) : 1'b0;

    assign w_lo = (w_m < SEG_A) ? 1'b0 :
                  (w_m < SEG_B) ? (20 * w_r + 10 * w_z + 40 <= w_m * (10 + w_z)) :
                  (w_m < SEG_C) ? (8 * w_r + 2 * w_m <= 104 + 4 * w_z) :
                  (w_m < SEG_D) ? (4 * w_z * (w_m + 38) + 200 * w_m >= 600 * w_r + 3400) :
                  (w_m < SEG_E) ? (1000 * w_r + 250 * w_m <= w_z * (360 + 5 * w_m) + 20000) : 1'b0;

    assign w_data = (w_up && w_lo && !w_off) ? i_color : '0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_v <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_a[i] <= '0;
                r_d[i] <= '0;
            end
        end else begin
            if (i_flush)
                r_v <= '0;
            else if (i_en)
                r_v <= {r_v[PIPE_DEPTH-2:0], i_valid};
            if (i_en) begin
                r_a[0] <= i_addr;
                r_d[0] <= w_data;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    r_a[i] <= r_a[i-1];
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

    assign o_valid = r_v[PIPE_DEPTH-1];
    assign o_addr  = r_a[PIPE_DEPTH-1];
    assign o_data  = r_d[PIPE_DEPTH-1];

endmodule

// File: rtl/mouth_raster_engine.sv
// mouth_raster_engine: rasterises a mouth shape, one pixel per advance cycle,
// from the newest buffered face sample, with ready/valid output back-pressure.
// Ports:
//   clk_in, rst_in                clock, asynchronous active-low reset
//   face_data_valid               strobe loading mouth_openness/mouth_color
//   mouth_openness, mouth_color   openness z and lit-pixel colour
//   pixel_address/data/valid      pixel stream, held while pixel_ready is low
//   pixel_ready                   downstream acceptance
//   busy                          high while a frame is in progress
//   frame_done                    one-cycle pulse after the last pixel is taken
//   abort_in                      cancels the frame in progress
module mouth_raster_engine
    import mouth_raster_engine_pkg::*;
#(
    parameter  int NUM_BLOCK_ROWS = 16,
    parameter  int NUM_PIXELS     = 128,
    parameter  int FACE_RES       = 65536,
    parameter  int LOG_POWER_MOD  = 4,
    parameter  int PIPE_DEPTH     = 4,
    parameter  int MIRROR_EN      = 1,
    localparam int LOG_FACE_RES   = $clog2(FACE_RES),
    localparam int PIXEL_SIZE     = pixel_size(LOG_POWER_MOD),
    localparam int AW             = addr_width(NUM_BLOCK_ROWS, NUM_PIXELS)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    face_data_valid,
    input  logic [LOG_FACE_RES-1:0] mouth_openness,
    input  logic [PIXEL_SIZE-1:0]   mouth_color,
    output logic [AW-1:0]           pixel_address,
    output logic [PIXEL_SIZE-1:0]   pixel_data,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic                    busy,
    output logic                    frame_done,
    input  logic                    abort_in
);

    localparam int RW = cnt_width(NUM_BLOCK_ROWS);
    localparam int CW = cnt_width(NUM_PIXELS);

    state_t r_state, w_next;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic [LOG_FACE_RES-1:0] r_z, r_buf_z;
    logic [PIXEL_SIZE-1:0]   r_color, r_buf_color;
    logic                    r_buf_full, r_frame_done;
    logic                    w_advance, w_abort, w_start, w_issue, w_last_col, w_last_pos, w_last_accept;
    logic [AW-1:0]           w_addr;

    // The whole pipeline moves unless a presented pixel is being refused.
    assign w_advance     = !(pixel_valid && !pixel_ready);
    assign w_abort       = abort_in && r_state != S_IDLE;
    assign w_start       = r_state == S_IDLE && r_buf_full;
    assign w_issue       = r_state == S_DRAWING && w_advance && !abort_in;
    assign w_last_col    = r_col == CW'(NUM_PIXELS - 1);
    assign w_last_pos    = w_last_col && r_row == RW'(NUM_BLOCK_ROWS - 1);
    // Pixels leave in raster order, so the final address marks the frame end.
    assign w_last_accept = pixel_valid && pixel_ready && pixel_address == AW'(NUM_BLOCK_ROWS * NUM_PIXELS - 1);
    assign w_addr        = AW'(32'(r_row) * 32'(NUM_PIXELS) + 32'(r_col));
    assign busy          = r_state != S_IDLE;
    assign frame_done    = r_frame_done;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (r_buf_full) w_next = S_DRAWING;
            S_DRAWING: if (w_abort) w_next = S_IDLE; else if (w_issue && w_last_pos) w_next = S_DRAIN;
            S_DRAIN:   if (w_abort || w_last_accept) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_row        <= '0;
            r_col        <= '0;
            r_z          <= '0;
            r_color      <= '0;
            r_buf_z      <= '0;
            r_buf_color  <= '0;
            r_buf_full   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_state == S_DRAIN && w_last_accept && !abort_in;
            if (w_start) begin
                r_z     <= r_buf_z;
                r_color <= r_buf_color;
                r_row   <= '0;
                r_col   <= '0;
            end else if (w_issue) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                r_row <= w_last_col ? r_row + 1'b1 : r_row;
            end
            // A strobe in the latch cycle refills the buffer for the next frame.
            if (face_data_valid) begin
                r_buf_z     <= mouth_openness;
                r_buf_color <= mouth_color;
                r_buf_full  <= 1'b1;
            end else if (w_start) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    mouth_shape_eval #(
        .NUM_PIXELS (NUM_PIXELS),
        .PIPE_DEPTH (PIPE_DEPTH),
        .MIRROR_EN  (MIRROR_EN),
        .RW         (RW),
        .CW         (CW),
        .ZW         (LOG_FACE_RES),
        .PS         (PIXEL_SIZE),
        .AW         (AW)
    ) u_shape (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (w_advance),
        .i_flush (w_abort),
        .i_valid (w_issue),
        .i_row   (r_row),
        .i_col   (r_col),
        .i_z     (r_z),
        .i_color (r_color),
        .i_addr  (w_addr),
        .o_valid (pixel_valid),
        .o_addr  (pixel_address),
        .o_data  (pixel_data)
    );

endmodule

// File: tb/tb_mouth_raster_engine.sv
// tb_mouth_raster_engine: directed self-checking bench for mouth_raster_engine
// (full-mirror instance plus a right-half-only instance driven in lockstep).
module tb_mouth_raster_engine;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        face_data_valid = 1'b0;
    logic [15:0] mouth_openness = '0;
    logic [11:0] mouth_color = '0;
    logic        pixel_ready = 1'b1;
    logic        abort_in = 1'b0;
    logic [10:0] pixel_address, h_address;
    logic [11:0] pixel_data, h_data;
    logic        pixel_valid, h_valid, busy, h_busy, frame_done, h_done;
    logic [11:0] got1 [2048];
    logic [11:0] got0 [2048];
    int          checks = 0;
    int          errors = 0;

    always #5 clk_in = ~clk_in;

    mouth_raster_engine #(.MIRROR_EN(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .face_data_valid(face_data_valid),
        .mouth_openness(mouth_openness), .mouth_color(mouth_color),
        .pixel_address(pixel_address), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .busy(busy), .frame_done(frame_done), .abort_in(abort_in)
    );

    mouth_raster_engine #(.MIRROR_EN(0)) dut_half (
        .clk_in(clk_in), .rst_in(rst_in), .face_data_valid(face_data_valid),
        .mouth_openness(mouth_openness), .mouth_color(mouth_color),
        .pixel_address(h_address), .pixel_data(h_data), .pixel_valid(h_valid),
        .pixel_ready(pixel_ready), .busy(h_busy), .frame_done(h_done), .abort_in(abort_in)
    );

    function automatic bit model_lit(input int addr, input longint z, input bit mir);
        longint r, c, m;
        r = addr / 128;
        c = addr % 128;
        if (!mir && c >= 64) return 1'b0;
        m = (mir && 127 - c < c) ? 127 - c : c;
        if (m < 10 || m >= 64) return 1'b0;
        if (m < 20) return (m + 6 <= 2 * r + 12) && (20 * r + 10 * z + 40 <= m * (10 + z));
        if (m < 32) return (4 * r + 4 + m >= 52) && (8 * r + 2 * m <= 104 + 4 * z);
        if (m < 44) return (m + 15 <= 3 * r + 35) && (4 * z * (m + 38) + 200 * m >= 600 * r + 3400);
        return (4 * r + 4 + m >= 80) && (1000 * r + 250 * m <= z * (360 + 5 * m) + 20000);
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_sample(input logic [15:0] z, input logic [11:0] c);
        mouth_openness  = z;
        mouth_color     = c;
        face_data_valid = 1'b1;
        tick();
        face_data_valid = 1'b0;
    endtask

    task automatic collect(input string name, input longint z, input logic [11:0] colr,
                           input int stall_at, input int stall_len);
        int idx = 0, held = 0, addr_err = 0, data_err = 0, half_err = 0, early = 0;
        bit done = 1'b0;
        logic fd = 1'b0, bz = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            got1[i] = 'x;
            got0[i] = 'x;
        end
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            tick();
            if (idx == 2048) begin
                fd   = frame_done;
                bz   = busy;
                done = 1'b1;
            end else begin
                if (frame_done) early++;
                pixel_ready = !(stall_at >= 0 && pixel_valid && int'(pixel_address) == stall_at && held < stall_len);
                if (!pixel_ready) held++;
                if (pixel_valid && pixel_ready) begin
                    if (int'(pixel_address) != idx) addr_err++;
                    if (pixel_data !== (model_lit(idx, z, 1'b1) ? colr : 12'h000)) data_err++;
                    if (!h_valid || int'(h_address) != idx || h_data !== (model_lit(idx, z, 1'b0) ? colr : 12'h000)) half_err++;
                    got1[idx] = pixel_data;
                    got0[idx] = h_data;
                    idx++;
                end
            end
        end
        pixel_ready = 1'b1;
        checks++; if (idx != 2048) begin errors++; $display("FAIL %s pixel_count got %0d want 2048", name, idx); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL %s address_order bad %0d want 0", name, addr_err); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL %s mirror_data bad %0d want 0", name, data_err); end
        checks++; if (half_err != 0) begin errors++; $display("FAIL %s half_data bad %0d want 0", name, half_err); end
        checks++; if (early != 0) begin errors++; $display("FAIL %s early_frame_done got %0d want 0", name, early); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL %s frame_done got %b want 1", name, fd); end
        checks++; if (bz !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, bz); end
        if (stall_at >= 0) begin
            checks++; if (held != stall_len) begin errors++; $display("FAIL %s stall_hold got %0d want %0d", name, held, stall_len); end
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        repeat (3) tick();
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pixel_valid); end
        checks++; if (pixel_address !== 11'd0) begin errors++; $display("FAIL reset_address got %0d want 0", pixel_address); end
        checks++; if (pixel_data !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", pixel_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        rst_in = 1'b1;
    endtask

    task automatic test_idle;
        int act = 0;
        repeat (20) begin
            tick();
            if (pixel_valid || busy || frame_done) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL idle_activity got %0d want 0", act); end
    endtask

    task automatic test_full_frame;
        int diff = 0;
        send_sample(16'd0, 12'hFFF);
        collect("full_frame", 0, 12'hFFF, -1, 0);
        checks++; if (got1[1932] !== 12'h000) begin errors++; $display("FAIL r15c12 got %h want 000", got1[1932]); end
        checks++; if (got1[916] !== 12'hFFF) begin errors++; $display("FAIL r7c20 got %h want FFF", got1[916]); end
        checks++; if (got1[654] !== 12'hFFF) begin errors++; $display("FAIL r5c14 got %h want FFF", got1[654]); end
        checks++; if (got1[1003] !== 12'hFFF) begin errors++; $display("FAIL r7c107_mirror got %h want FFF", got1[1003]); end
        checks++; if (got0[1003] !== 12'h000) begin errors++; $display("FAIL r7c107_half got %h want 000", got0[1003]); end
        checks++; if (got0[916] !== 12'hFFF) begin errors++; $display("FAIL r7c20_half got %h want FFF", got0[916]); end
        for (int i = 0; i < 2048; i++)
            if ((i % 128) < 64 && got0[i] !== got1[i]) diff++;
        checks++; if (diff != 0) begin errors++; $display("FAIL half_vs_mirror_left got %0d want 0", diff); end
    endtask

    task automatic test_stall;
        send_sample(16'd0, 12'hA5A);
        collect("stall", 0, 12'hA5A, 300, 5);
    endtask

    task automatic test_newest_sample;
        send_sample(16'd0, 12'h123);
        fork
            collect("newest_first", 0, 12'h123, -1, 0);
            begin
                repeat (200) tick();
                send_sample(16'd10, 12'h111);
                repeat (300) tick();
                send_sample(16'd40, 12'h3C3);
            end
        join
        collect("newest_second", 40, 12'h3C3, -1, 0);
        checks++; if (got1[651] !== 12'h3C3) begin errors++; $display("FAIL r5c11_z40 got %h want 3C3", got1[651]); end
    endtask

    task automatic test_abort;
        bit hit = 1'b0;
        int seen = 0;
        // Second strobe lands in the latch cycle and must survive for the next frame.
        send_sample(16'd0, 12'h0F0);
        send_sample(16'd40, 12'h00F);
        for (int cyc = 0; cyc < 5000 && !hit; cyc++) begin
            tick();
            if (frame_done) seen++;
            if (pixel_valid && pixel_address == 11'd1000) begin
                hit = 1'b1;
                abort_in = 1'b1;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach_1000 got 0 want 1"); end
        tick();
        abort_in = 1'b0;
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", pixel_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0 || seen != 0) begin errors++; $display("FAIL abort_frame_done got %b/%0d want 0/0", frame_done, seen); end
        collect("after_abort", 40, 12'h00F, -1, 0);
        checks++; if (got1[651] !== 12'h00F) begin errors++; $display("FAIL after_abort_r5c11 got %h want 00F", got1[651]); end
    endtask

    task automatic test_reset_mid;
        int n = 0, act = 0;
        send_sample(16'd0, 12'h777);
        for (int cyc = 0; cyc < 2000 && n < 100; cyc++) begin
            tick();
            if (pixel_valid) n++;
        end
        send_sample(16'd40, 12'h0F0);
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if (pixel_valid !== 1'b0 || h_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b%b want 00", pixel_valid, h_valid); end
        checks++; if (pixel_address !== 11'd0) begin errors++; $display("FAIL midreset_address got %0d want 0", pixel_address); end
        checks++; if (pixel_data !== 12'h000) begin errors++; $display("FAIL midreset_data got %h want 000", pixel_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_frame_done got %b want 0", frame_done); end
        repeat (3) tick();
        rst_in = 1'b1;
        repeat (50) begin
            tick();
            if (pixel_valid || busy) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL post_reset_activity got %0d want 0", act); end
        send_sample(16'd10, 12'hABC);
        collect("after_reset", 10, 12'hABC, -1, 0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_full_frame();
        test_stall();
        test_newest_sample();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
